// File: rtl/md5_resp_tx.sv
// rtl/md5_resp_tx.sv - frames one md5 core result (sync, status, payload, xor checksum) into the UART transmitter
module md5_resp_tx #(
  parameter int          DATA_BYTES = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'h7E
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    res_valid,
  output logic                    res_ready,
  input  logic                    res_match,
  input  logic [8*DATA_BYTES-1:0] res_data,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic                    frame_busy,
  output logic [15:0]             frame_count
);

  localparam int PW = 8 * DATA_BYTES;
  localparam int IW = $clog2(DATA_BYTES + 3);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BYTES + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [PW-1:0] payload;
  logic          match_q;
  logic [7:0]    chk;
  logic [7:0]    cur_byte;

  // Payload is shifted left after each payload byte, so the next one is always at the top.
  always_comb begin
    cur_byte = chk;
    if (idx == IW'(0))
      cur_byte = SYNC_BYTE;
    else if (idx == IW'(1))
      cur_byte = {7'b0, match_q};
    else if (idx != LAST_IDX)
      cur_byte = payload[PW-1 -: 8];
  end

  assign res_ready  = (state == S_IDLE);
  assign frame_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      payload     <= '0;
      match_q     <= 1'b0;
      chk         <= 8'h00;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      frame_count <= 16'h0000;
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (res_valid) begin
            payload <= res_data;
            match_q <= res_match;
            idx     <= '0;
            chk     <= 8'h00;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= cur_byte;
            // SYNC and the checksum byte itself stay out of the running checksum.
            if (idx != IW'(0) && idx != LAST_IDX)
              chk <= chk ^ cur_byte;
            if (idx >= IW'(2) && idx != LAST_IDX)
              payload <= payload << 8;
            state <= S_HOLD;
          end
        end
        // The transmitter raises busy only one cycle after start, so skip one cycle before watching it.
        S_HOLD: state <= S_WAIT;
        S_WAIT: begin
          if (!tx_busy) begin
            if (idx == LAST_IDX) begin
              frame_count <= frame_count + 16'd1;
              state       <= S_IDLE;
            end else begin
              idx   <= idx + IW'(1);
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
